instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have a single clock, clk; reset, rst, is asynchronous and active-high.
REQ-002 Ports, in order:
- clk  in  1  system clock
- rst  in  1  async active-high reset
- start  in  1  pulse: begin fetching at start_addr
- start_addr  in  16  first program address
- imem_en  out  1  instruction-memory read strobe
- imem_addr  out  16  instruction-memory word address
- imem_rdata  in  32  read data, valid the cycle after imem_en
- ir_out  out  32  instruction to execute stage; fields oper[31:27], rdst[26:22], rsrc1[21:17], imm_mode[16], rsrc2[15:11], isrc[15:0]
- ir_valid  out  1  ir_out holds a valid instruction
- ir_ready  in  1  execute stage accepts ir_out
- redirect  in  1  execute stage forces a new PC
- redirect_addr  in  16  target PC for redirect
- pc_out  out  16  address of the instruction in ir_out
- halted  out  1  halt opcode issued, fetch stopped

Function
REQ-003 SHALL implement FSM states IDLE, REQ, WAIT, ISSUE, HALT.
REQ-004 IDLE: on start, pc <= start_addr, go to REQ; all other inputs ignored.
REQ-005 REQ: imem_en=1, imem_addr=pc for exactly one cycle, then go to WAIT.
REQ-006 WAIT: ir_out <= imem_rdata, pc_out <= pc, then go to ISSUE; ir_valid rises on the following cycle.
REQ-007 ISSUE: ir_valid=1 and ir_out/pc_out held stable until ir_valid&ir_ready.
REQ-008 On handshake: if oper == OP_HALT (5'b11111), go to HALT; otherwise pc <= pc+1 and go to REQ.
REQ-009 Minimum issue interval SHALL be 3 cycles per instruction (REQ, WAIT, ISSUE).
REQ-010 PC SHALL wrap from 16'hFFFF to 16'h0000 with no error indication.
REQ-011 redirect in REQ/WAIT/ISSUE: pc <= redirect_addr, next state REQ, any in-flight read data is discarded, ir_valid=0 from the next cycle.
REQ-012 redirect in the same cycle as a handshake: the instruction counts as consumed, and redirect_addr takes priority over pc+1 and over halt.
REQ-013 redirect in IDLE or HALT SHALL be ignored.
REQ-014 HALT: halted=1, imem_en=0, ir_valid=0; start restarts exactly as from IDLE and clears halted.
REQ-015 start outside IDLE/HALT SHALL be ignored.
REQ-016 imem_en SHALL be asserted only in REQ.

Reset
REQ-017 rst asserted (asynchronously) SHALL force IDLE, pc=0, pc_out=0, ir_out=0, ir_valid=0, imem_en=0, imem_addr=0, halted=0.
REQ-018 Reset mid-fetch SHALL drop the pending read; read data returning after reset release SHALL be ignored.
REQ-019 The first action after reset release SHALL occur only on start.

Configuration
REQ-020 Macro FETCH_COND_EN SHALL add inputs cond_sel[1:0] and flags[3:0] = {sign, zero, overflow, carry}.
REQ-021 With FETCH_COND_EN defined, redirect is taken only when flags[cond_sel] = 1 (0=carry, 1=overflow, 2=zero, 3=sign); otherwise it is ignored.
REQ-022 Without FETCH_COND_EN, those ports SHALL be absent and redirect is unconditional.

Structure
REQ-023 A shared package SHALL hold the IR field bit positions, all opcode constants (movsgpr..rnot, OP_HALT), the FSM state enum, and the flag index constants.
REQ-024 One sub-module, fetch_pc, SHALL own the PC register, increment/wrap and redirect/start muxing; the FSM stays in instr_fetch.

Verification
REQ-025 Reset, start with start_addr=16'h0010, ir_ready=1 tied, memory holding mov,add,halt at 0x10-0x12 -> three issues with pc_out 0x10, 0x11, 0x12, 3 cycles apart, then halted=1 and imem_en=0.
REQ-026 Hold ir_ready=0 for 5 cycles in ISSUE -> ir_out and pc_out stable, ir_valid=1, and no imem_en pulse.
REQ-027 Assert redirect with redirect_addr=16'h0040 during WAIT -> the returned word is discarded, the next imem_addr is 0x40, and the next issued pc_out is 0x40.
REQ-028 Handshake and redirect to 16'h0080 in the same cycle on a halt instruction -> halted stays 0 and the next fetch is at 0x80.
REQ-029 start_addr=16'hFFFF, non-halt instruction -> the next imem_addr is 16'h0000.
REQ-030 Assert rst during WAIT -> all outputs are at reset values immediately (asynchronously), and with FETCH_COND_EN, flags=4'b0100 and cond_sel=2 makes redirect taken while cond_sel=0 makes it ignored.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: IR field layout, opcodes,
// fetch FSM states and condition-flag indices.
package instr_fetch_pkg;

  localparam int OPER_MSB     = 31;
  localparam int OPER_LSB     = 27;
  localparam int RDST_MSB     = 26;
  localparam int RDST_LSB     = 22;
  localparam int RSRC1_MSB    = 21;
  localparam int RSRC1_LSB    = 17;
  localparam int IMM_MODE_BIT = 16;
  localparam int RSRC2_MSB    = 15;
  localparam int RSRC2_LSB    = 11;
  localparam int ISRC_MSB     = 15;
  localparam int ISRC_LSB     = 0;

  localparam logic [4:0] OP_MOVSGPR = 5'd0;
  localparam logic [4:0] OP_MOV     = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4;
  localparam logic [4:0] OP_ROR     = 5'd5;
  localparam logic [4:0] OP_RAND    = 5'd6;
  localparam logic [4:0] OP_RXOR    = 5'd7;
  localparam logic [4:0] OP_RXNOR   = 5'd8;
  localparam logic [4:0] OP_RNAND   = 5'd9;
  localparam logic [4:0] OP_RNOR    = 5'd10;
  localparam logic [4:0] OP_RNOT    = 5'd11;
  localparam logic [4:0] OP_HALT    = 5'b11111;

  // Bit positions inside flags = {sign, zero, overflow, carry}.
  localparam int FLAG_CARRY    = 0;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_ZERO     = 2;
  localparam int FLAG_SIGN     = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } fetch_state_t;

  function automatic logic [4:0] ir_oper(input logic [31:0] ir);
    return ir[OPER_MSB:OPER_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_pc.sv
// Program counter for the fetch unit: redirect/start load and wrapping increment.
// pc_next is exposed so the fetch FSM can register the next read address.
module fetch_pc (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_load,
  input  logic [15:0] start_addr,
  input  logic        redirect_load,
  input  logic [15:0] redirect_addr,
  input  logic        incr,
  output logic [15:0] pc,
  output logic [15:0] pc_next
);

  // Redirect wins over everything; the 16-bit add wraps FFFF -> 0000 by itself.
  always_comb begin
    pc_next = pc;
    if (redirect_load)
      pc_next = redirect_addr;
    else if (start_load)
      pc_next = start_addr;
    else if (incr)
      pc_next = pc + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= 16'h0000;
    else
      pc <= pc_next;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: REQ/WAIT/ISSUE loop with redirect and halt handling.
// Optional macro FETCH_COND_EN adds cond_sel/flags to gate redirect on a flag.
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] start_addr,
  output logic        imem_en,
  output logic [15:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir_out,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  output logic [15:0] pc_out,
  output logic        halted
`ifdef FETCH_COND_EN
  ,
  input  logic [1:0]  cond_sel,
  input  logic [3:0]  flags
`endif
);

  // ir_valid/ir_ready: an instruction transfers on a cycle where both are high;
  // ir_out and pc_out stay frozen while ir_valid is high and ir_ready is low.

  fetch_state_t state;
  logic [15:0]  pc;
  logic [15:0]  pc_next;
  logic         cond_ok;
  logic         active;
  logic         redirect_take;
  logic         start_take;
  logic         handshake;
  logic         is_halt;
  logic         incr;

`ifdef FETCH_COND_EN
  assign cond_ok = flags[cond_sel];
`else
  assign cond_ok = 1'b1;
`endif

  assign active        = (state == S_REQ) || (state == S_WAIT) || (state == S_ISSUE);
  assign redirect_take = active && redirect && cond_ok;
  assign start_take    = ((state == S_IDLE) || (state == S_HALT)) && start;
  assign handshake     = (state == S_ISSUE) && ir_valid && ir_ready;
  assign is_halt       = (ir_oper(ir_out) == OP_HALT);
  assign incr          = handshake && !is_halt && !redirect_take;

  fetch_pc u_pc (
    .clk           (clk),
    .rst           (rst),
    .start_load    (start_take),
    .start_addr    (start_addr),
    .redirect_load (redirect_take),
    .redirect_addr (redirect_addr),
    .incr          (incr),
    .pc            (pc),
    .pc_next       (pc_next)
  );

  // Every path into REQ registers imem_en/imem_addr so the strobe lines up with S_REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      imem_en   <= 1'b0;
      imem_addr <= 16'h0000;
      ir_out    <= 32'h0000_0000;
      ir_valid  <= 1'b0;
      pc_out    <= 16'h0000;
      halted    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start_take) begin
            state     <= S_REQ;
            imem_en   <= 1'b1;
            imem_addr <= pc_next;
            halted    <= 1'b0;
          end
        end
        S_REQ: begin
          if (redirect_take) begin
            state     <= S_REQ;
            imem_en   <= 1'b1;
            imem_addr <= pc_next;
          end else begin
            state   <= S_WAIT;
            imem_en <= 1'b0;
          end
        end
        S_WAIT: begin
          if (redirect_take) begin
            state     <= S_REQ;
            imem_en   <= 1'b1;
            imem_addr <= pc_next;
          end else begin
            state    <= S_ISSUE;
            ir_out   <= imem_rdata;
            pc_out   <= pc;
            ir_valid <= 1'b1;
          end
        end
        S_ISSUE: begin
          // A redirect overrides both the sequential fetch and a halt being consumed.
          if (redirect_take || (handshake && !is_halt)) begin
            state     <= S_REQ;
            imem_en   <= 1'b1;
            imem_addr <= pc_next;
            ir_valid  <= 1'b0;
          end else if (handshake) begin
            state    <= S_HALT;
            ir_valid <= 1'b0;
            halted   <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_en  <= 1'b0;
          ir_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a one-cycle-latency instruction memory model.
// Build with +define+FETCH_COND_EN to also exercise conditional redirect.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] start_addr;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ir_out;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic [15:0] pc_out;
  logic        halted;
  logic [1:0]  cond_sel;
  logic [3:0]  flags;

  int n_vec;
  int n_err;
  int cyc;

  localparam logic [31:0] I_MOV  = {OP_MOV, 5'd1, 5'd0, 1'b1, 16'h0005};
  localparam logic [31:0] I_ADD  = {OP_ADD, 5'd2, 5'd1, 1'b0, 5'd1, 11'd0};
  localparam logic [31:0] I_SUB  = {OP_SUB, 5'd3, 5'd2, 1'b0, 5'd1, 11'd0};
  localparam logic [31:0] I_HALT = {OP_HALT, 27'd0};
  localparam logic [31:0] I_NOP  = {OP_MOVSGPR, 5'd4, 22'd0};

  instr_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .start_addr    (start_addr),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .ir_out        (ir_out),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .pc_out        (pc_out),
    .halted        (halted)
`ifdef FETCH_COND_EN
    ,
    .cond_sel      (cond_sel),
    .flags         (flags)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0010: return I_MOV;
      16'h0011: return I_ADD;
      16'h0012: return I_HALT;
      16'h0020: return I_ADD;
      16'h0021: return I_SUB;
      16'h0040: return I_HALT;
      16'hFFFF: return I_MOV;
      default:  return I_NOP;
    endcase
  endfunction

  always @(posedge clk) if (imem_en) imem_rdata <= mem_word(imem_addr);

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] a);
    start      = 1'b1;
    start_addr = a;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int at);
    for (int i = 0; i < 20 && !ir_valid; i++) tick();
    at = cyc;
    if (!ir_valid) check("valid_timeout", {31'd0, ir_valid}, 32'd1);
  endtask

  int c0, c1, c2;

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; start_addr = 16'h0; ir_ready = 1'b1;
    redirect = 1'b0; redirect_addr = 16'h0; cond_sel = 2'd0; flags = 4'd0;
    tick();
    check("rst_imem_en",  {31'd0, imem_en},  32'd0);
    check("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    check("rst_halted",   {31'd0, halted},   32'd0);
    check("rst_pc_out",   {16'd0, pc_out},   32'd0);
    do_reset();

    // three-instruction program with ir_ready tied high
    do_start(16'h0010);
    check("p_req_en",   {31'd0, imem_en},  32'd1);
    check("p_req_addr", {16'd0, imem_addr}, 32'h0010);
    wait_valid(c0);
    check("p0_ir", ir_out, I_MOV);
    check("p0_pc", {16'd0, pc_out}, 32'h0010);
    tick();
    wait_valid(c1);
    check("p1_ir", ir_out, I_ADD);
    check("p1_pc", {16'd0, pc_out}, 32'h0011);
    check("p1_gap", c1 - c0, 32'd3);
    tick();
    wait_valid(c2);
    check("p2_ir", ir_out, I_HALT);
    check("p2_pc", {16'd0, pc_out}, 32'h0012);
    check("p2_gap", c2 - c1, 32'd3);
    tick();
    check("h_halted", {31'd0, halted},   32'd1);
    check("h_en",     {31'd0, imem_en},  32'd0);
    check("h_valid",  {31'd0, ir_valid}, 32'd0);

    // redirect while halted is ignored
    redirect = 1'b1; redirect_addr = 16'h0055;
    tick();
    redirect = 1'b0;
    tick();
    check("h_redir_halted", {31'd0, halted},  32'd1);
    check("h_redir_en",     {31'd0, imem_en}, 32'd0);

    // restart from HALT, then stall in ISSUE
    ir_ready = 1'b0;
    do_start(16'h0020);
    check("rs_halted", {31'd0, halted}, 32'd0);
    check("rs_addr",   {16'd0, imem_addr}, 32'h0020);
    wait_valid(c0);
    check("st_ir0", ir_out, I_ADD);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("st_valid", {31'd0, ir_valid}, 32'd1);
      check("st_ir",    ir_out, I_ADD);
      check("st_pc",    {16'd0, pc_out}, 32'h0020);
      check("st_en",    {31'd0, imem_en}, 32'd0);
    end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    check("st_next_en",   {31'd0, imem_en},  32'd1);
    check("st_next_addr", {16'd0, imem_addr}, 32'h0021);
    check("st_next_vld",  {31'd0, ir_valid}, 32'd0);

    // redirect during WAIT discards the word read from 0x21
    tick();
    check("w_en", {31'd0, imem_en}, 32'd0);
    redirect = 1'b1; redirect_addr = 16'h0040;
    tick();
    redirect = 1'b0;
    check("rw_en",    {31'd0, imem_en},  32'd1);
    check("rw_addr",  {16'd0, imem_addr}, 32'h0040);
    check("rw_valid", {31'd0, ir_valid}, 32'd0);
    wait_valid(c0);
    check("rw_pc", {16'd0, pc_out}, 32'h0040);
    check("rw_ir", ir_out, I_HALT);

    // handshake of a halt together with redirect: redirect wins
    ir_ready = 1'b1; redirect = 1'b1; redirect_addr = 16'h0080;
    tick();
    ir_ready = 1'b0; redirect = 1'b0;
    check("hr_halted", {31'd0, halted},   32'd0);
    check("hr_en",     {31'd0, imem_en},  32'd1);
    check("hr_addr",   {16'd0, imem_addr}, 32'h0080);

    // start while fetching is ignored
    do_start(16'h0010);
    wait_valid(c0);
    check("ns_pc", {16'd0, pc_out}, 32'h0080);
    check("ns_ir", ir_out, I_NOP);

    // redirect in IDLE is ignored
    do_reset();
    redirect = 1'b1; redirect_addr = 16'h0055;
    tick();
    tick();
    redirect = 1'b0;
    check("ir_en",   {31'd0, imem_en},  32'd0);
    check("ir_addr", {16'd0, imem_addr}, 32'h0000);

    // PC wrap
    ir_ready = 1'b1;
    do_start(16'hFFFF);
    check("wr_addr0", {16'd0, imem_addr}, 32'hFFFF);
    wait_valid(c0);
    check("wr_pc", {16'd0, pc_out}, 32'hFFFF);
    tick();
    check("wr_en",   {31'd0, imem_en},  32'd1);
    check("wr_addr", {16'd0, imem_addr}, 32'h0000);

    // asynchronous reset during WAIT
    tick();
    #2 rst = 1'b1;
    #1;
    check("ar_en",     {31'd0, imem_en},  32'd0);
    check("ar_addr",   {16'd0, imem_addr}, 32'h0000);
    check("ar_ir",     ir_out, 32'h0000_0000);
    check("ar_valid",  {31'd0, ir_valid}, 32'd0);
    check("ar_pc",     {16'd0, pc_out},   32'h0000);
    check("ar_halted", {31'd0, halted},   32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_en",    {31'd0, imem_en},  32'd0);
      check("post_valid", {31'd0, ir_valid}, 32'd0);
    end

`ifdef FETCH_COND_EN
    // conditional redirect: flags = {sign,zero,ovf,carry} = 0100
    ir_ready = 1'b0;
    do_start(16'h0010);
    wait_valid(c0);
    flags = 4'b0100; cond_sel = 2'd0;
    redirect = 1'b1; redirect_addr = 16'h0040;
    tick();
    check("cn_valid", {31'd0, ir_valid}, 32'd1);
    check("cn_pc",    {16'd0, pc_out},   32'h0010);
    check("cn_en",    {31'd0, imem_en},  32'd0);
    cond_sel = 2'd2;
    tick();
    redirect = 1'b0;
    check("ct_en",    {31'd0, imem_en},  32'd1);
    check("ct_addr",  {16'd0, imem_addr}, 32'h0040);
    check("ct_valid", {31'd0, ir_valid}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
